particle_stream_receiver: RTL and testbench
===========================================

Name: particle_stream_receiver

Overview:
- Receiving end of the inter-FPGA particle link: captures the quad-lane SPI-style stream (copi/dclk/cs) emitted by the simulation FPGA each frame.
- Reassembles 16-bit particle words and writes them into a double-banked particle buffer on the rendering FPGA.
- Commits a bank to the renderer only after a frame with exactly the expected word count.

Parameters:
- DATA_WIDTH, 16, bits per particle word.
- DATA_LINES, 4, copi lanes; DATA_WIDTH must be a multiple of DATA_LINES.
- ELEMENTS, 2, words per frame (PARTICLE_COUNT*DIMS*2).
- ADDR_WIDTH, $clog2(ELEMENTS), per-bank index width; minimum 1.
- SYNC_STAGES, 2, synchronizer depth on copi/dclk/cs.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- copi_in  input  DATA_LINES  serial data lanes, asynchronous.
- dclk_in  input  1  link clock from transmitter, asynchronous.
- cs_in  input  1  frame select, active low, asynchronous.
- addr_out  output  ADDR_WIDTH+1  buffer write address; MSB = write bank, LSBs = word index.
- mem_out  output  DATA_WIDTH  buffer write data.
- mem_write_enable  output  1  one-cycle write strobe.
- mem_enable  output  1  equals mem_write_enable.
- bank_out  output  1  bank currently valid for the renderer.
- frame_done  output  1  one-cycle pulse: good frame committed.
- frame_error  output  1  one-cycle pulse: frame rejected.

Behaviour:
- Reset (synchronous, active high): all outputs 0; state IDLE; counters and shift register cleared; synchronizer flops load cs=1, dclk=0, copi=0.
- Synchronizers: all three inputs pass through SYNC_STAGES flops of equal depth, so copi stays aligned with dclk.
  - dclk_rise = synced dclk & ~previous synced dclk.
  - cs_fall / cs_rise are derived the same way on synced cs.
- Link timing requirement: dclk high and low phases each ≥ SYNC_STAGES+1 clk_in cycles.
- States:
  - IDLE: wait for cs_fall, then clear nibble_cnt, word_cnt, overflow and shift; go to RECEIVE. Holding cs low does not start a frame; only a falling edge does.
  - RECEIVE, on dclk_rise:
    - Shift: shift <= {shift[DATA_WIDTH-DATA_LINES-1:0], copi_sync}, MSB nibble first.
    - nibble_cnt increments and wraps at DATA_WIDTH/DATA_LINES.
  - RECEIVE, word completion (the dclk_rise that completes a word):
    - Next cycle, if word_cnt < ELEMENTS: mem_write_enable=mem_enable=1 for exactly one cycle, mem_out = assembled word, addr_out = {~bank_out, word_cnt}; word_cnt++.
    - If word_cnt == ELEMENTS: no write; set overflow.
  - RECEIVE, on cs_rise:
    - Good frame (word_cnt==ELEMENTS, nibble_cnt==0, !overflow): frame_done=1 next cycle and bank_out toggles in that same cycle.
    - Otherwise: frame_error=1 next cycle, bank_out unchanged, any partial word discarded.
    - Either way, return to IDLE.
- Priority: a cs_rise coinciding with a dclk_rise ignores the dclk_rise.
- A pending word write issued in the cycle of a cs_rise still completes, and is counted before the frame check.
- frame_done and frame_error are never asserted together.
- Writes never target bank bank_out; the renderer-visible bank is never corrupted, including by rejected frames.
- word_cnt width is ADDR_WIDTH+1 so it can hold ELEMENTS without wrapping.
- Reset mid-frame: immediate IDLE, no further writes; the next frame requires a fresh cs high→low edge.

Test Plan:
1. Reset, then frame of 0x1234, 0xABCD (ELEMENTS=2, 4 lanes, 4 dclk per word) → writes addr 2'b10=0x1234 and 2'b11=0xABCD, one cycle each; frame_done pulse; bank_out 0→1.
2. Follow-on frame of 0x0001, 0xFFFF → writes to addr 2'b00 and 2'b01; frame_done; bank_out 1→0.
3. Short frame with one word 0x5555 → single write to 2'b10; frame_error pulse; bank_out stays 0.
4. Overflow frame with 3 words (0x1111, 0x2222, 0x3333) → only two writes (0x1111 @2'b10, 0x2222 @2'b11); 0x3333 dropped; frame_error; bank unchanged.
5. Frame of 2 words plus 2 extra nibbles → both writes occur; frame_error (partial word); bank unchanged.
6. Reset asserted after first word with cs held low and dclk still toggling → outputs 0, no writes. Then cs high, low, and a 2-word frame → normal writes to bank 1; frame_done.

Source files
------------

// File: rtl/particle_stream_receiver.sv
// Receiver for the quad-lane inter-FPGA particle link: synchronizes copi/dclk/cs,
// reassembles words into the hidden bank and commits the bank only on a clean frame.
module particle_stream_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_LINES  = 4,
  parameter int ELEMENTS    = 2,
  parameter int ADDR_WIDTH  = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [DATA_LINES-1:0] copi_in,
  input  logic                  dclk_in,
  input  logic                  cs_in,
  output logic [ADDR_WIDTH:0]   addr_out,
  output logic [DATA_WIDTH-1:0] mem_out,
  output logic                  mem_write_enable,
  output logic                  mem_enable,
  output logic                  bank_out,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam int NIBBLES = DATA_WIDTH / DATA_LINES;
  localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, RECEIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][DATA_LINES-1:0] copi_sync_r;
  logic [SYNC_STAGES-1:0]                 dclk_sync_r;
  logic [SYNC_STAGES-1:0]                 cs_sync_r;
  logic [SYNC_STAGES:0]                   sync_fill;
  logic                                   dclk_prev, cs_prev, cs_armed;

  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic [NIB_W-1:0]      nibble_cnt;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic                  overflow;

  logic start, shift_en, word_done, frame_end, good;

  wire [DATA_LINES-1:0] copi_s = copi_sync_r[SYNC_STAGES-1];
  wire dclk_s    = dclk_sync_r[SYNC_STAGES-1];
  wire cs_s      = cs_sync_r[SYNC_STAGES-1];
  wire dclk_rise = dclk_s & ~dclk_prev;
  wire cs_rise   = cs_s & ~cs_prev;
  // A fall only counts once cs has been seen high after reset, so a cs held low
  // through reset cannot masquerade as a new frame.
  wire cs_fall   = ~cs_s & cs_prev & cs_armed;

  generate
    if (NIBBLES > 1) begin : g_shift
      assign shift_next = {shift[DATA_WIDTH-DATA_LINES-1:0], copi_s};
    end else begin : g_shift_one
      assign shift_next = copi_s;
    end
  endgenerate

  assign mem_enable = mem_write_enable;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    start     = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    frame_end = 1'b0;
    good      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          start   = 1'b1;
          state_d = RECEIVE;
        end
      end
      RECEIVE: begin
        if (cs_rise) begin
          frame_end = 1'b1;
          good      = (word_cnt == (ADDR_WIDTH+1)'(ELEMENTS)) && (nibble_cnt == '0) && !overflow;
          state_d   = IDLE;
        end else if (dclk_rise) begin
          shift_en  = 1'b1;
          word_done = (nibble_cnt == NIB_W'(NIBBLES - 1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (rst) begin
      state_q          <= IDLE;
      copi_sync_r      <= '0;
      dclk_sync_r      <= '0;
      cs_sync_r        <= '1;
      sync_fill        <= '0;
      dclk_prev        <= 1'b0;
      cs_prev          <= 1'b1;
      cs_armed         <= 1'b0;
      shift            <= '0;
      nibble_cnt       <= '0;
      word_cnt         <= '0;
      overflow         <= 1'b0;
      addr_out         <= '0;
      mem_out          <= '0;
      mem_write_enable <= 1'b0;
      bank_out         <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      state_q     <= state_d;
      copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], copi_in};
      dclk_sync_r <= {dclk_sync_r[SYNC_STAGES-2:0], dclk_in};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_in};
      sync_fill   <= {sync_fill[SYNC_STAGES-1:0], 1'b1};
      dclk_prev   <= dclk_s;
      cs_prev     <= cs_s;
      if (sync_fill[SYNC_STAGES] && cs_s) cs_armed <= 1'b1;

      mem_write_enable <= 1'b0;
      frame_done       <= 1'b0;
      frame_error      <= 1'b0;

      if (start) begin
        shift      <= '0;
        nibble_cnt <= '0;
        word_cnt   <= '0;
        overflow   <= 1'b0;
      end

      if (shift_en) begin
        shift      <= shift_next;
        nibble_cnt <= (nibble_cnt == NIB_W'(NIBBLES - 1)) ? '0 : nibble_cnt + 1'b1;
      end

      if (word_done) begin
        if (word_cnt < (ADDR_WIDTH+1)'(ELEMENTS)) begin
          mem_write_enable <= 1'b1;
          mem_out          <= shift_next;
          addr_out         <= {~bank_out, word_cnt[ADDR_WIDTH-1:0]};
          word_cnt         <= word_cnt + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (frame_end) begin
        if (good) begin
          frame_done <= 1'b1;
          bank_out   <= ~bank_out;
        end else begin
          frame_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_particle_stream_receiver.sv
// Directed bench for particle_stream_receiver: drives framed nibble streams and
// checks buffer writes, commit/reject pulses and bank switching.
module tb_particle_stream_receiver;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  copi_in = '0;
  logic        dclk_in = 1'b0;
  logic        cs_in = 1'b1;
  logic [1:0]  addr_out;
  logic [15:0] mem_out;
  logic        mem_write_enable, mem_enable, bank_out, frame_done, frame_error;

  int checks = 0;
  int errors = 0;

  // Observed activity, recorded once per cycle away from the active edge.
  logic [1:0]  wr_addr [256];
  logic [15:0] wr_data [256];
  int wr_total = 0, done_total = 0, err_total = 0, both_total = 0, en_mis = 0;

  particle_stream_receiver dut (
    .clk_in(clk_in), .rst(rst), .copi_in(copi_in), .dclk_in(dclk_in), .cs_in(cs_in),
    .addr_out(addr_out), .mem_out(mem_out), .mem_write_enable(mem_write_enable),
    .mem_enable(mem_enable), .bank_out(bank_out), .frame_done(frame_done),
    .frame_error(frame_error)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (mem_write_enable) begin
      if (wr_total < 256) begin
        wr_addr[wr_total] = addr_out;
        wr_data[wr_total] = mem_out;
      end
      wr_total++;
    end
    if (frame_done)  done_total++;
    if (frame_error) err_total++;
    if (frame_done && frame_error) both_total++;
    if (mem_enable !== mem_write_enable) en_mis++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // dclk phases of 4 clk cycles satisfy the SYNC_STAGES+1 minimum.
  task automatic send_nibble(input logic [3:0] n);
    copi_in = n;
    dclk_in = 1'b0;
    wait_clk(4);
    dclk_in = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_nibble(w[15:12]);
    send_nibble(w[11:8]);
    send_nibble(w[7:4]);
    send_nibble(w[3:0]);
  endtask

  task automatic frame_begin();
    cs_in = 1'b0;
    wait_clk(4);
  endtask

  task automatic frame_end();
    cs_in = 1'b1;
    wait_clk(8);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [1:0] a, input logic [15:0] d);
    check({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
    check({tag, "_data"}, 32'(wr_data[idx]), 32'(d));
  endtask

  int bw, bd, be;

  task automatic snap();
    bw = wr_total;
    bd = done_total;
    be = err_total;
  endtask

  initial begin
    wait_clk(4);
    check("rst_addr", 32'(addr_out), 0);
    check("rst_data", 32'(mem_out), 0);
    check("rst_we", 32'(mem_write_enable), 0);
    check("rst_bank", 32'(bank_out), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err", 32'(frame_error), 0);
    rst = 1'b0;
    wait_clk(6);

    // 1: good frame into bank 1
    snap();
    frame_begin();
    send_word(16'h1234);
    send_word(16'hABCD);
    frame_end();
    check("f1_writes", 32'(wr_total - bw), 2);
    check_write("f1_w0", bw, 2'b10, 16'h1234);
    check_write("f1_w1", bw + 1, 2'b11, 16'hABCD);
    check("f1_done", 32'(done_total - bd), 1);
    check("f1_err", 32'(err_total - be), 0);
    check("f1_bank", 32'(bank_out), 1);

    // 2: good frame into bank 0
    snap();
    frame_begin();
    send_word(16'h0001);
    send_word(16'hFFFF);
    frame_end();
    check("f2_writes", 32'(wr_total - bw), 2);
    check_write("f2_w0", bw, 2'b00, 16'h0001);
    check_write("f2_w1", bw + 1, 2'b01, 16'hFFFF);
    check("f2_done", 32'(done_total - bd), 1);
    check("f2_bank", 32'(bank_out), 0);

    // 3: short frame
    snap();
    frame_begin();
    send_word(16'h5555);
    frame_end();
    check("f3_writes", 32'(wr_total - bw), 1);
    check_write("f3_w0", bw, 2'b10, 16'h5555);
    check("f3_done", 32'(done_total - bd), 0);
    check("f3_err", 32'(err_total - be), 1);
    check("f3_bank", 32'(bank_out), 0);

    // 4: overflow frame, third word dropped
    snap();
    frame_begin();
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    frame_end();
    check("f4_writes", 32'(wr_total - bw), 2);
    check_write("f4_w0", bw, 2'b10, 16'h1111);
    check_write("f4_w1", bw + 1, 2'b11, 16'h2222);
    check("f4_done", 32'(done_total - bd), 0);
    check("f4_err", 32'(err_total - be), 1);
    check("f4_bank", 32'(bank_out), 0);

    // 5: two words plus a partial word
    snap();
    frame_begin();
    send_word(16'hCAFE);
    send_word(16'hBEEF);
    send_nibble(4'h1);
    send_nibble(4'h2);
    frame_end();
    check("f5_writes", 32'(wr_total - bw), 2);
    check_write("f5_w0", bw, 2'b10, 16'hCAFE);
    check_write("f5_w1", bw + 1, 2'b11, 16'hBEEF);
    check("f5_done", 32'(done_total - bd), 0);
    check("f5_err", 32'(err_total - be), 1);
    check("f5_bank", 32'(bank_out), 0);

    // 6: reset mid-frame with cs held low and dclk still toggling
    frame_begin();
    send_word(16'h7777);
    snap();
    rst = 1'b1;
    send_word(16'h8888);
    check("f6_rst_addr", 32'(addr_out), 0);
    check("f6_rst_data", 32'(mem_out), 0);
    check("f6_rst_we", 32'(mem_write_enable), 0);
    check("f6_rst_bank", 32'(bank_out), 0);
    rst = 1'b0;
    send_word(16'h9999);
    send_word(16'hAAAA);
    wait_clk(8);
    check("f6_no_writes", 32'(wr_total - bw), 0);
    check("f6_no_done", 32'(done_total - bd), 0);
    check("f6_no_err", 32'(err_total - be), 0);
    cs_in = 1'b1;
    wait_clk(8);
    check("f6_idle_err", 32'(err_total - be), 0);
    snap();
    frame_begin();
    send_word(16'h4242);
    send_word(16'h1357);
    frame_end();
    check("f6_writes", 32'(wr_total - bw), 2);
    check_write("f6_w0", bw, 2'b10, 16'h4242);
    check_write("f6_w1", bw + 1, 2'b11, 16'h1357);
    check("f6_done", 32'(done_total - bd), 1);
    check("f6_err", 32'(err_total - be), 0);
    check("f6_bank", 32'(bank_out), 1);

    check("done_err_overlap", 32'(both_total), 0);
    check("mem_enable_match", 32'(en_mis), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
